// File: rtl/vx_warp_ibuffer.sv
// Per-warp instruction buffer: one FIFO per warp, round-robin selection into a registered dispatch slot.
// Optional build macro IBUF_PERF_EN adds saturating stall counters perf_full_stalls / perf_disp_stalls.

module vx_warp_ibuffer_checker (
    input logic clk,
    input logic reset,
    input logic push,
    input logic push_full,
    input logic dec_valid,
    input logic wid_ok
);
    a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push && push_full))
        else $error("vx_warp_ibuffer: push into a full warp FIFO");
    a_wid_range: assert property (@(posedge clk) disable iff (reset) dec_valid |-> wid_ok)
        else $error("vx_warp_ibuffer: dec_wid out of range");
endmodule

module vx_warp_ibuffer #(
    parameter int NUM_WARPS = 4,
    parameter int IBUF_SIZE = 2,
    parameter int DATAW     = 128,
    parameter int NW_BITS   = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dec_valid,
    input  logic [NW_BITS-1:0]   dec_wid,
    input  logic [DATAW-1:0]     dec_data,
    output logic                 dec_ready,
    output logic [NUM_WARPS-1:0] warp_full,
    output logic [NUM_WARPS-1:0] warp_empty,
    output logic                 ibuf_valid,
    output logic [NW_BITS-1:0]   ibuf_wid,
    output logic [DATAW-1:0]     ibuf_data,
    input  logic                 ibuf_ready
`ifdef IBUF_PERF_EN
    ,
    output logic [31:0]          perf_full_stalls,
    output logic [31:0]          perf_disp_stalls
`endif
);
    localparam int PTR_W = $clog2(IBUF_SIZE);
    localparam int CNT_W = PTR_W + 1;
    localparam int WID_W = NW_BITS + 1;
    localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(IBUF_SIZE);
    localparam logic [WID_W-1:0]   WID_LIMIT = WID_W'(NUM_WARPS);
    localparam logic [NW_BITS-1:0] RR_INIT   = NW_BITS'(NUM_WARPS - 1);

    logic [DATAW-1:0]     mem_r    [NUM_WARPS][IBUF_SIZE];
    logic [PTR_W-1:0]     rd_ptr_r [NUM_WARPS];
    logic [PTR_W-1:0]     wr_ptr_r [NUM_WARPS];
    logic [CNT_W-1:0]     count_r  [NUM_WARPS];
    logic [NW_BITS-1:0]   rr_r;

    logic [NUM_WARPS-1:0] nonempty_s;
    logic [NUM_WARPS-1:0] push_vec_s;
    logic [NUM_WARPS-1:0] pop_vec_s;
    logic [NW_BITS-1:0]   sel_s;
    logic                 sel_found_s;
    logic                 take_s;
    logic                 wid_ok_s;
    logic                 push_s;
    logic                 push_full_s;
    logic                 slot_free_s;
    int                   idx_s;

    // Per-warp status flags; a warp is only empty once its slot entry has also left
    always_comb begin
        nonempty_s = '0;
        warp_full  = '0;
        warp_empty = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            nonempty_s[w] = (count_r[w] != '0);
            warp_full[w]  = (count_r[w] == CNT_FULL);
            warp_empty[w] = !nonempty_s[w] && !(ibuf_valid && (ibuf_wid == NW_BITS'(w)));
        end
    end

    // Decode handshake: full warps back-pressure even when popped this cycle
    always_comb begin
        wid_ok_s = ({1'b0, dec_wid} < WID_LIMIT);
        if (wid_ok_s) begin
            push_full_s = warp_full[dec_wid];
        end else begin
            push_full_s = 1'b1;
        end
        dec_ready = !push_full_s;
        push_s    = dec_valid && dec_ready;
    end

    // Round-robin search starting just after the last selected warp
    always_comb begin
        sel_s       = '0;
        sel_found_s = 1'b0;
        take_s      = 1'b0;
        idx_s       = 0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            idx_s       = (int'(rr_r) + i) % NUM_WARPS;
            take_s      = !sel_found_s && nonempty_s[idx_s[NW_BITS-1:0]];
            sel_s       = take_s ? idx_s[NW_BITS-1:0] : sel_s;
            sel_found_s = sel_found_s | take_s;
        end
        slot_free_s = !ibuf_valid || ibuf_ready;
    end

    // Decode per-warp push and pop strobes
    always_comb begin
        push_vec_s = '0;
        pop_vec_s  = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            push_vec_s[w] = push_s && (dec_wid == NW_BITS'(w));
            pop_vec_s[w]  = slot_free_s && sel_found_s && (sel_s == NW_BITS'(w));
        end
    end

    // FIFO pointers, occupancy, round-robin pointer and the output slot
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                rd_ptr_r[w] <= '0;
                wr_ptr_r[w] <= '0;
                count_r[w]  <= '0;
            end
            rr_r       <= RR_INIT;
            ibuf_valid <= 1'b0;
            ibuf_wid   <= '0;
            ibuf_data  <= '0;
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (push_vec_s[w]) begin
                    wr_ptr_r[w] <= wr_ptr_r[w] + PTR_ONE;
                end
                if (pop_vec_s[w]) begin
                    rd_ptr_r[w] <= rd_ptr_r[w] + PTR_ONE;
                end
                case ({push_vec_s[w], pop_vec_s[w]})
                    2'b10:   count_r[w] <= count_r[w] + CNT_ONE;
                    2'b01:   count_r[w] <= count_r[w] - CNT_ONE;
                    default: count_r[w] <= count_r[w];
                endcase
            end
            if (slot_free_s) begin
                if (sel_found_s) begin
                    ibuf_valid <= 1'b1;
                    ibuf_wid   <= sel_s;
                    ibuf_data  <= mem_r[sel_s][rd_ptr_r[sel_s]];
                    rr_r       <= sel_s;
                end else begin
                    ibuf_valid <= 1'b0;
                end
            end
        end
    end

    // Payload storage needs no reset: occupancy counters gate every read
    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (push_vec_s[w]) begin
                mem_r[w][wr_ptr_r[w]] <= dec_data;
            end
        end
    end

`ifdef IBUF_PERF_EN
    // Saturating stall counters
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_full_stalls <= 32'd0;
            perf_disp_stalls <= 32'd0;
        end else begin
            if (dec_valid && !dec_ready && (perf_full_stalls != 32'hFFFF_FFFF)) begin
                perf_full_stalls <= perf_full_stalls + 32'd1;
            end
            if (ibuf_valid && !ibuf_ready && (perf_disp_stalls != 32'hFFFF_FFFF)) begin
                perf_disp_stalls <= perf_disp_stalls + 32'd1;
            end
        end
    end
`endif

    vx_warp_ibuffer_checker u_checker (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_full (push_full_s),
        .dec_valid (dec_valid),
        .wid_ok    (wid_ok_s)
    );

endmodule

// File: tb/tb_vx_warp_ibuffer.sv
// Self-checking bench for vx_warp_ibuffer: queue-based reference model, per-cycle compare, directed scenarios
// plus randomized traffic with occasional mid-run resets.
module tb_vx_warp_ibuffer;
    localparam int NUM_WARPS = 4;
    localparam int IBUF_SIZE = 2;
    localparam int DATAW     = 128;
    localparam int NW_BITS   = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 dec_valid;
    logic [NW_BITS-1:0]   dec_wid;
    logic [DATAW-1:0]     dec_data;
    logic                 dec_ready;
    logic [NUM_WARPS-1:0] warp_full;
    logic [NUM_WARPS-1:0] warp_empty;
    logic                 ibuf_valid;
    logic [NW_BITS-1:0]   ibuf_wid;
    logic [DATAW-1:0]     ibuf_data;
    logic                 ibuf_ready;
`ifdef IBUF_PERF_EN
    logic [31:0]          perf_full_stalls;
    logic [31:0]          perf_disp_stalls;
`endif

    vx_warp_ibuffer #(
        .NUM_WARPS (NUM_WARPS),
        .IBUF_SIZE (IBUF_SIZE),
        .DATAW     (DATAW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .dec_valid  (dec_valid),
        .dec_wid    (dec_wid),
        .dec_data   (dec_data),
        .dec_ready  (dec_ready),
        .warp_full  (warp_full),
        .warp_empty (warp_empty),
        .ibuf_valid (ibuf_valid),
        .ibuf_wid   (ibuf_wid),
        .ibuf_data  (ibuf_data),
        .ibuf_ready (ibuf_ready)
`ifdef IBUF_PERF_EN
        ,
        .perf_full_stalls (perf_full_stalls),
        .perf_disp_stalls (perf_disp_stalls)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string nm, input logic [DATAW-1:0] act, input logic [DATAW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one queue per warp plus a single output slot
    logic [DATAW-1:0]   mq [NUM_WARPS][$];
    bit                 m_valid = 1'b0;
    logic [NW_BITS-1:0] m_wid   = '0;
    logic [DATAW-1:0]   m_data  = '0;
    int                 m_rr    = NUM_WARPS - 1;
    longint             m_pfull = 0;
    longint             m_pdisp = 0;

    always @(posedge clk) begin
        int  sel;
        int  w;
        bit  push;
        if (reset) begin
            for (int k = 0; k < NUM_WARPS; k++) mq[k].delete();
            m_valid = 1'b0;
            m_wid   = '0;
            m_data  = '0;
            m_rr    = NUM_WARPS - 1;
            m_pfull = 0;
            m_pdisp = 0;
        end else begin
            push = dec_valid && (mq[dec_wid].size() < IBUF_SIZE);
            if (dec_valid && !push) m_pfull++;
            if (m_valid && !ibuf_ready) m_pdisp++;
            if (!m_valid || ibuf_ready) begin
                sel = -1;
                for (int k = 1; k <= NUM_WARPS; k++) begin
                    w = (m_rr + k) % NUM_WARPS;
                    if (sel < 0 && mq[w].size() > 0) sel = w;
                end
                if (sel >= 0) begin
                    m_valid = 1'b1;
                    m_wid   = NW_BITS'(sel);
                    m_data  = mq[sel].pop_front();
                    m_rr    = sel;
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (push) mq[dec_wid].push_back(dec_data);
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic [NUM_WARPS-1:0] ef;
        logic [NUM_WARPS-1:0] ee;
        if (chk_en) begin
            for (int k = 0; k < NUM_WARPS; k++) begin
                ef[k] = (mq[k].size() == IBUF_SIZE);
                ee[k] = (mq[k].size() == 0) && !(m_valid && (int'(m_wid) == k));
            end
            check("ibuf_valid", DATAW'(ibuf_valid), DATAW'(m_valid));
            if (m_valid) begin
                check("ibuf_wid", DATAW'(ibuf_wid), DATAW'(m_wid));
                check("ibuf_data", ibuf_data, m_data);
            end
            check("warp_full", DATAW'(warp_full), DATAW'(ef));
            check("warp_empty", DATAW'(warp_empty), DATAW'(ee));
            check("dec_ready", DATAW'(dec_ready), DATAW'(mq[dec_wid].size() < IBUF_SIZE));
`ifdef IBUF_PERF_EN
            check("perf_full", DATAW'(perf_full_stalls), DATAW'(m_pfull));
            check("perf_disp", DATAW'(perf_disp_stalls), DATAW'(m_pdisp));
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int w, input logic [DATAW-1:0] d);
        dec_valid = 1'b1;
        dec_wid   = NW_BITS'(w);
        dec_data  = d;
        cyc();
    endtask

    task automatic slot_is(input string nm, input int w, input logic [DATAW-1:0] d);
        check({nm, "_valid"}, DATAW'(ibuf_valid), DATAW'(1'b1));
        check({nm, "_wid"}, DATAW'(ibuf_wid), DATAW'(w));
        check({nm, "_data"}, ibuf_data, d);
    endtask

    int exp_w [6];
    logic [DATAW-1:0] exp_d [6];

    initial begin
        reset = 1'b1; dec_valid = 1'b0; dec_wid = '0; dec_data = '0; ibuf_ready = 1'b0;
        cyc();
        chk_en = 1'b1;
        cyc(); cyc();
        reset = 1'b0;

        // Reset state
        check("rst_valid", DATAW'(ibuf_valid), DATAW'(1'b0));
        check("rst_empty", DATAW'(warp_empty), DATAW'(4'b1111));
        check("rst_full", DATAW'(warp_full), DATAW'(4'b0000));
        check("rst_wid", DATAW'(ibuf_wid), DATAW'(2'd0));
        check("rst_data", ibuf_data, '0);
        for (int w = 0; w < NUM_WARPS; w++) begin
            dec_wid = NW_BITS'(w);
            cyc();
            check("rst_ready", DATAW'(dec_ready), DATAW'(1'b1));
        end

        // Two-edge latency, no bypass
        ibuf_ready = 1'b1;
        push(2, 128'hA5);
        dec_valid = 1'b0;
        check("lat_not_yet", DATAW'(ibuf_valid), DATAW'(1'b0));
        cyc();
        slot_is("lat", 2, 128'hA5);
        cyc();
        check("lat_drained", DATAW'(ibuf_valid), DATAW'(1'b0));
        check("lat_empty2", DATAW'(warp_empty[2]), DATAW'(1'b1));

        // Fill warp 1 under dispatch stall
        ibuf_ready = 1'b0;
        push(1, 128'h11);
        push(1, 128'h12);
        push(1, 128'h13);
        dec_data = 128'h14;
        check("full_w1", DATAW'(warp_full[1]), DATAW'(1'b1));
        check("full_ready1", DATAW'(dec_ready), DATAW'(1'b0));
        dec_wid = 2'd0;
        #1;
        check("full_ready0", DATAW'(dec_ready), DATAW'(1'b1));
        dec_wid = 2'd1;
        slot_is("full_slot", 1, 128'h11);
        cyc();
        dec_valid = 1'b0;
        ibuf_ready = 1'b1;
        slot_is("drain0", 1, 128'h11);
        cyc();
        slot_is("drain1", 1, 128'h12);
        cyc();
        slot_is("drain2", 1, 128'h13);
        cyc();
        check("drain_done", DATAW'(ibuf_valid), DATAW'(1'b0));

        // Round-robin over warps 0,1,3 with no bubbles
        ibuf_ready = 1'b0;
        push(0, 128'hA0); push(0, 128'hA1);
        push(1, 128'hB0); push(1, 128'hB1);
        push(3, 128'hC0); push(3, 128'hC1);
        dec_valid = 1'b0;
        ibuf_ready = 1'b1;
        exp_w = '{0, 1, 3, 0, 1, 3};
        exp_d = '{128'hA0, 128'hB0, 128'hC0, 128'hA1, 128'hB1, 128'hC1};
        for (int i = 0; i < 6; i++) begin
            slot_is("rr", exp_w[i], exp_d[i]);
            cyc();
        end
        check("rr_done", DATAW'(ibuf_valid), DATAW'(1'b0));

        // Stall holds slot stable while warp 0 fills
        push(3, 128'h7);
        dec_valid = 1'b0;
        cyc();
        ibuf_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            slot_is("hold", 3, 128'h7);
            push(0, DATAW'(8'h80 + 8'(i)));
        end
        slot_is("hold_end", 3, 128'h7);
        dec_valid = 1'b0;
        ibuf_ready = 1'b1;
        cyc();
        slot_is("after_hold0", 0, 128'h80);
        cyc();
        slot_is("after_hold1", 0, 128'h81);
        cyc();
        check("after_hold_done", DATAW'(ibuf_valid), DATAW'(1'b0));

`ifdef IBUF_PERF_EN
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        ibuf_ready = 1'b0;
        push(2, 128'h1); push(2, 128'h2); push(2, 128'h3);
        push(2, 128'h4); push(2, 128'h4); push(2, 128'h4);
        dec_valid = 1'b0;
        ibuf_ready = 1'b1;
        cyc();
        check("perf_full_lit", DATAW'(perf_full_stalls), DATAW'(32'd3));
        check("perf_disp_lit", DATAW'(perf_disp_stalls), DATAW'(32'd4));
        cyc(); cyc(); cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("perf_full_rst", DATAW'(perf_full_stalls), DATAW'(32'd0));
        check("perf_disp_rst", DATAW'(perf_disp_stalls), DATAW'(32'd0));
`endif

        // Randomized traffic with occasional mid-run resets
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 299) == 0);
            dec_valid  = ($urandom_range(0, 3) != 0);
            dec_wid    = ($urandom_range(0, 2) == 0) ? 2'd1 : NW_BITS'($urandom_range(0, NUM_WARPS - 1));
            dec_data   = {$urandom, $urandom, $urandom, $urandom};
            ibuf_ready = (i % 500 < 250) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            cyc();
        end
        reset = 1'b0;
        dec_valid = 1'b0;
        ibuf_ready = 1'b1;
        repeat (20) cyc();
        check("final_empty", DATAW'(warp_empty), DATAW'(4'b1111));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
